// File: rtl/led_pattern_engine.sv
// rtl/led_pattern_engine.sv - prescaled LED pattern generator with FLASH/SHIFT/SHIFT2 modes.
// Define LED_BOUNCE_MODE_EN to build the fourth BOUNCE mode.
module led_pattern_engine #(
  parameter int NB_LEDS     = 4,
  parameter int NB_SW       = 4,
  parameter int NB_BTN      = 4,
  parameter int NB_COUNTER  = 32,
  parameter int BASE_PERIOD = 2**20
) (
  input  logic               clock,
  input  logic               i_reset,
  input  logic [NB_SW-1:0]   i_sw,
  input  logic [NB_BTN-1:0]  i_btn,
  output logic               o_tick,
  output logic [1:0]         o_mode,
  output logic [2:0]         o_color,
  output logic [NB_LEDS-1:0] o_led_r,
  output logic [NB_LEDS-1:0] o_led_g,
  output logic [NB_LEDS-1:0] o_led_b
);

  typedef enum logic [1:0] {
    FLASH  = 2'd0,
    SHIFT  = 2'd1,
    SHIFT2 = 2'd2,
    BOUNCE = 2'd3
  } mode_t;

  localparam logic [NB_COUNTER-1:0] BASE = NB_COUNTER'(BASE_PERIOD);

  logic [NB_COUNTER-1:0] count;
  logic [NB_COUNTER-1:0] limit;
  logic [NB_SW-3:0]      rate;
  mode_t                 mode;
  mode_t                 mode_next;
  logic [NB_LEDS-1:0]    pattern;
  logic [2:0]            color;
  logic                  btn_d;
  logic                  adv;
  logic                  shift_right;
`ifdef LED_BOUNCE_MODE_EN
  logic                  bounce_up;
`endif

  assign rate        = i_sw[NB_SW-2:1];
  assign limit       = (BASE << rate) - NB_COUNTER'(1);
  assign adv         = i_btn[0] & ~btn_d;
  assign shift_right = i_sw[NB_SW-1];
  assign o_mode      = mode;
  assign o_color     = color;

  always_comb begin
    mode_next = mode_t'(mode + 2'd1);
`ifndef LED_BOUNCE_MODE_EN
    if (mode == SHIFT2) mode_next = FLASH;
`endif
  end

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      count     <= '0;
      o_tick    <= 1'b0;
      mode      <= FLASH;
      pattern   <= '0;
      color     <= 3'b001;
      btn_d     <= 1'b1;
      o_led_r   <= '0;
      o_led_g   <= '0;
      o_led_b   <= '0;
`ifdef LED_BOUNCE_MODE_EN
      bounce_up <= 1'b1;
`endif
    end else begin
      btn_d <= i_btn[0];

      if (i_btn[1])      color <= 3'b001;
      else if (i_btn[2]) color <= 3'b010;
      else if (i_btn[3]) color <= 3'b100;

      if (!i_sw[0]) begin
        count  <= '0;
        o_tick <= 1'b0;
      end else if (count >= limit) begin
        count  <= '0;
        o_tick <= 1'b1;
      end else begin
        count  <= count + NB_COUNTER'(1);
        o_tick <= 1'b0;
      end

      // A mode step takes priority and swallows a coincident tick.
      if (adv) begin
        mode <= mode_next;
        case (mode_next)
          SHIFT:   pattern <= NB_LEDS'(1);
          SHIFT2:  pattern <= NB_LEDS'(3);
`ifdef LED_BOUNCE_MODE_EN
          BOUNCE: begin
            pattern   <= NB_LEDS'(1);
            bounce_up <= 1'b1;
          end
`endif
          default: pattern <= '0;
        endcase
      end else if (o_tick) begin
        case (mode)
          FLASH: pattern <= ~pattern;
          SHIFT, SHIFT2: begin
            if (shift_right) pattern <= {pattern[0], pattern[NB_LEDS-1:1]};
            else             pattern <= {pattern[NB_LEDS-2:0], pattern[NB_LEDS-1]};
          end
`ifdef LED_BOUNCE_MODE_EN
          // Direction flips on the step that lands on an end, so ends never dwell.
          BOUNCE: begin
            if (bounce_up) begin
              pattern <= pattern << 1;
              if (pattern[NB_LEDS-2]) bounce_up <= 1'b0;
            end else begin
              pattern <= pattern >> 1;
              if (pattern[1]) bounce_up <= 1'b1;
            end
          end
`endif
          default: pattern <= pattern;
        endcase
      end

      o_led_r <= color[0] ? pattern : '0;
      o_led_b <= color[1] ? pattern : '0;
      o_led_g <= color[2] ? pattern : '0;
    end
  end

endmodule

// File: doc/led_pattern_engine.md
LED_PATTERN_ENGINE -- requirements
Module: led_pattern_engine

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- NB_LEDS, 4, LEDs per colour bank; legal values are 2 or more.
- NB_SW, 4, switch width.
- NB_BTN, 4, button width.
- NB_COUNTER, 32, prescaler width.
- BASE_PERIOD, 2**20, tick period in clocks at rate 0.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clock, in, 1, the single clock.
- i_reset, in, 1, asynchronous, active-low reset.
- i_sw, in, NB_SW: [0] run enable; [NB_SW-2:1] rate select; [NB_SW-1] shift direction.
- i_btn, in, NB_BTN: [0] mode advance; [1] red; [2] blue; [3] green.
- o_tick, out, 1, one-cycle pattern-step strobe.
- o_mode, out, 2, current mode.
- o_color, out, 3, one-hot colour: bit0 red, bit1 blue, bit2 green.
- o_led_r, out, NB_LEDS, red bank.
- o_led_g, out, NB_LEDS, green bank.
- o_led_b, out, NB_LEDS, blue bank.

Function
REQ-003 The block SHALL define limit = (BASE_PERIOD << rate) - 1, where rate = i_sw[NB_SW-2:1], computed in NB_COUNTER bits.
REQ-004 While i_sw[0]=1, the prescaler SHALL increment each clock; when count >= limit, o_tick SHALL be 1 for that cycle and count SHALL clear to 0.
REQ-005 While i_sw[0]=0, count SHALL clear to 0 and hold, and o_tick SHALL stay 0.
- A rate change mid-count SHALL cause no extra logic.
- Because the compare is >=, a count already above the new limit SHALL produce a tick at once.
REQ-006 A mode-advance edge SHALL be defined as i_btn[0]=1 while its one-cycle-delayed sample is 0.
REQ-007 Each mode-advance edge SHALL step the mode FLASH(0) -> SHIFT(1) -> SHIFT2(2) -> BOUNCE(3) -> FLASH(0).
REQ-008 On a mode step, the pattern SHALL reload as follows:
- FLASH: all zeros.
- SHIFT: 1 in bit 0.
- SHIFT2: 1s in bits 1:0.
- BOUNCE: 1 in bit 0, bounce direction up.
REQ-009 On o_tick, the pattern SHALL update as follows:
- FLASH: invert all bits.
- SHIFT and SHIFT2: rotate by 1 position; left (toward MSB) when i_sw[NB_SW-1]=0, right otherwise; wrap-around is circular.
- BOUNCE: move the single lit bit 1 position in the bounce direction.
REQ-010 In BOUNCE, the direction SHALL reverse on the tick that reaches bit NB_LEDS-1 or bit 0, with no dwell.
- For NB_LEDS=4 the sequence SHALL be 0,1,2,3,2,1,0,1,...
- i_sw[NB_SW-1] SHALL be ignored in BOUNCE.
REQ-011 When a mode-advance edge and o_tick occur in the same cycle, the mode step and reload SHALL win and that tick SHALL be discarded.
REQ-012 Colour select SHALL be sampled every clock with priority i_btn[1] > i_btn[2] > i_btn[3]:
- i_btn[1] SHALL load 001.
- i_btn[2] SHALL load 010.
- i_btn[3] SHALL load 100.
- With none pressed, the colour SHALL hold.
REQ-013 o_led_r, o_led_b and o_led_g SHALL be registered:
- Each SHALL equal the pattern when its colour bit is set, else 0.
- Each SHALL reflect a pattern or colour change exactly 1 clock after that register updates.
REQ-014 o_mode and o_color SHALL be direct register outputs with 0 added latency.

Reset
REQ-015 Assertion of i_reset=0 SHALL asynchronously force:
- count = 0, o_tick = 0;
- mode = FLASH, pattern = 0, bounce direction = up;
- colour = 001;
- all LED outputs = 0;
- the button-delay register = 1.
REQ-016 A button held through reset release SHALL NOT generate a mode-advance edge.
REQ-017 Reset asserted mid-operation SHALL abandon the current count and pattern immediately, with no completion of any step.

Configuration
REQ-018 With LED_BOUNCE_MODE_EN defined, BOUNCE SHALL be built and 4 modes SHALL cycle.
REQ-019 Without LED_BOUNCE_MODE_EN, BOUNCE logic SHALL be absent:
- SHIFT2 SHALL step to FLASH.
- o_mode SHALL never equal 3.

Verification (BASE_PERIOD=4, NB_LEDS=4)
REQ-020 i_sw=0001 (rate 0) -> o_tick every 4th clock; i_sw=0011 (rate 1) -> every 8th clock; i_sw[0]=0 -> no ticks and count=0.
REQ-021 Reset, then 1 i_btn[0] pulse (SHIFT), i_sw=0001, 5 ticks -> pattern 0001,0010,0100,1000,0001,0010; i_sw[3]=1 -> next tick 0001.
REQ-022 3 pulses (BOUNCE, macro defined), 8 ticks -> lit bit 1,2,3,2,1,0,1,2; same stimulus without macro -> o_mode back to 0 and pattern 0000.
REQ-023 Mode-advance edge forced in the same cycle as o_tick while in SHIFT at 0100 -> mode=SHIFT2, pattern=0011, no rotation.
REQ-024 i_btn[2] and i_btn[3] together -> o_color=010, o_led_b=pattern, o_led_r=o_led_g=0; then i_btn[1] -> 001 with red bank active 1 clock later.
REQ-025 i_reset pulled low mid-count while in BOUNCE with i_btn[0] held high through release -> all outputs reset immediately, o_color=001, mode stays FLASH after release.
